key_sequencer: RTL and testbench

//  Upstream stage of the ARC4 key-search pipeline. Walks 24-bit candidate keys over [key_start, key_stop].

---
 rtl/arc4_pkg.sv | 15 +
 rtl/key_byte_select.sv | 32 +++
 rtl/key_sequencer.sv | 128 ++++++++++++
 tb/tb_key_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared key-search definitions: key geometry and the key sequencer state encoding.
package arc4_pkg;

  localparam int KEY_BYTES = 3;
  localparam int KEY_WIDTH = KEY_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FOUND,
    EXHAUSTED
  } key_seq_state_t;

endpackage

// File: rtl/key_byte_select.sv
// Serves key byte (idx mod KEY_BYTES) to the KSA loop, byte 0 being the key MSB, with one cycle latency.
module key_byte_select
  import arc4_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic [7:0]           idx,
  output logic [7:0]           byte_out
);

  logic [7:0] w_sel;
  logic [7:0] w_byte;
  logic [7:0] r_byte;

  always_comb begin
    w_sel  = 8'(idx % 8'(KEY_BYTES));
    w_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (w_sel == 8'(k)) w_byte = key[KEY_WIDTH-1-8*k -: 8];
    end
  end

  // stage boundary: selected byte registered
  always_ff @(posedge clk) begin
    if (reset) r_byte <= '0;
    else       r_byte <= w_byte;
  end

  assign byte_out = r_byte;

endmodule

// File: rtl/key_sequencer.sv
// Walks candidate keys over [key_start, key_stop], launches one trial per key and
// collects checker verdicts until a key passes or the range runs out.
module key_sequencer
  import arc4_pkg::*;
#(
  parameter int KEY_STRIDE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] key_start,
  input  logic [KEY_WIDTH-1:0] key_stop,
  input  logic                 trial_pass,
  input  logic                 trial_fail,
  input  logic [7:0]           key_byte_idx,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 trial_start,
  output logic [7:0]           key_byte,
  output logic                 searching,
  output logic                 found,
  output logic                 exhausted,
  output logic [KEY_WIDTH-1:0] found_key,
  output logic [KEY_WIDTH-1:0] keys_tried
);

  key_seq_state_t       r_state;
  logic [KEY_WIDTH-1:0] r_key;
  logic [KEY_WIDTH-1:0] r_stop;
  logic [KEY_WIDTH-1:0] r_found_key;
  logic [KEY_WIDTH-1:0] r_keys_tried;
  logic                 r_trial_start;
  logic                 r_searching;
  logic                 r_found;
  logic                 r_exhausted;

  logic [KEY_WIDTH:0]   w_next_key;
  logic                 w_past_stop;
  logic [KEY_WIDTH-1:0] w_tried_inc;

  // One extra bit so a step past 2^KEY_WIDTH-1 reads as "beyond stop" instead of wrapping.
  assign w_next_key  = {1'b0, r_key} + (KEY_WIDTH+1)'(KEY_STRIDE);
  assign w_past_stop = w_next_key > {1'b0, r_stop};
  assign w_tried_inc = (r_keys_tried == '1) ? r_keys_tried : r_keys_tried + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_key         <= '0;
      r_stop        <= '0;
      r_found_key   <= '0;
      r_keys_tried  <= '0;
      r_trial_start <= 1'b0;
      r_searching   <= 1'b0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
    end else begin
      r_trial_start <= 1'b0;
      case (r_state)
        IDLE, FOUND, EXHAUSTED: begin
          if (start) begin
            r_key        <= key_start;
            r_stop       <= key_stop;
            r_keys_tried <= '0;
            r_found_key  <= '0;
            r_found      <= 1'b0;
            if (key_start > key_stop) begin
              r_state     <= EXHAUSTED;
              r_exhausted <= 1'b1;
              r_searching <= 1'b0;
            end else begin
              r_state       <= LAUNCH;
              r_trial_start <= 1'b1;
              r_exhausted   <= 1'b0;
              r_searching   <= 1'b1;
            end
          end
        end

        LAUNCH: r_state <= WAIT;

        WAIT: begin
          if (trial_pass) begin
            r_found_key  <= r_key;
            r_keys_tried <= w_tried_inc;
            r_state      <= FOUND;
            r_found      <= 1'b1;
            r_searching  <= 1'b0;
          end else if (trial_fail) begin
            r_keys_tried <= w_tried_inc;
            if (w_past_stop) begin
              r_state     <= EXHAUSTED;
              r_exhausted <= 1'b1;
              r_searching <= 1'b0;
            end else begin
              r_key         <= w_next_key[KEY_WIDTH-1:0];
              r_state       <= LAUNCH;
              r_trial_start <= 1'b1;
            end
          end
        end

        default: begin
          r_state     <= IDLE;
          r_searching <= 1'b0;
          r_found     <= 1'b0;
          r_exhausted <= 1'b0;
        end
      endcase
    end
  end

  key_byte_select u_key_byte_select (
    .clk      (clk),
    .reset    (reset),
    .key      (r_key),
    .idx      (key_byte_idx),
    .byte_out (key_byte)
  );

  assign key         = r_key;
  assign trial_start = r_trial_start;
  assign searching   = r_searching;
  assign found       = r_found;
  assign exhausted   = r_exhausted;
  assign found_key   = r_found_key;
  assign keys_tried  = r_keys_tried;

endmodule

// File: tb/tb_key_sequencer.sv
// Bench for key_sequencer: stride-1 and stride-2 instances driven by directed and random searches.
module tb_key_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        trial_pass = 1'b0;
  logic        trial_fail = 1'b0;
  logic [23:0] key_start = '0;
  logic [23:0] key_stop = '0;
  logic [7:0]  key_byte_idx = '0;
  bit          use2 = 1'b0;

  logic        start1, start2;
  assign start1 = start & ~use2;
  assign start2 = start & use2;

  logic [23:0] key1, fk1, kt1, key2, fk2, kt2;
  logic [7:0]  kb1, kb2;
  logic        ts1, srch1, fnd1, exh1, ts2, srch2, fnd2, exh2;

  key_sequencer #(.KEY_STRIDE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .key_start(key_start), .key_stop(key_stop),
    .trial_pass(trial_pass), .trial_fail(trial_fail), .key_byte_idx(key_byte_idx),
    .key(key1), .trial_start(ts1), .key_byte(kb1), .searching(srch1), .found(fnd1),
    .exhausted(exh1), .found_key(fk1), .keys_tried(kt1)
  );

  key_sequencer #(.KEY_STRIDE(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .key_start(key_start), .key_stop(key_stop),
    .trial_pass(trial_pass), .trial_fail(trial_fail), .key_byte_idx(key_byte_idx),
    .key(key2), .trial_start(ts2), .key_byte(kb2), .searching(srch2), .found(fnd2),
    .exhausted(exh2), .found_key(fk2), .keys_tried(kt2)
  );

  logic [23:0] m_key, m_fk, m_kt;
  logic [7:0]  m_kb;
  logic        m_ts, m_srch, m_fnd, m_exh;
  assign m_key  = use2 ? key2  : key1;
  assign m_fk   = use2 ? fk2   : fk1;
  assign m_kt   = use2 ? kt2   : kt1;
  assign m_kb   = use2 ? kb2   : kb1;
  assign m_ts   = use2 ? ts2   : ts1;
  assign m_srch = use2 ? srch2 : srch1;
  assign m_fnd  = use2 ? fnd2  : fnd1;
  assign m_exh  = use2 ? exh2  : exh1;

  int checks = 0;
  int errors = 0;
  int ts_cnt = 0;

  always @(negedge clk) if (m_ts === 1'b1) ts_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_key"}, 32'(m_key), 0);
    chk({tag, "_ts"},  32'(m_ts), 0);
    chk({tag, "_kb"},  32'(m_kb), 0);
    chk({tag, "_srch"}, 32'(m_srch), 0);
    chk({tag, "_fnd"}, 32'(m_fnd), 0);
    chk({tag, "_exh"}, 32'(m_exh), 0);
    chk({tag, "_fk"},  32'(m_fk), 0);
    chk({tag, "_kt"},  32'(m_kt), 0);
  endtask

  // Reference: candidates are s, s+stride, ... while <= e; the pass_at-th trial (0-based) passes.
  task automatic search(input logic [23:0] s, input logic [23:0] e, input int stride,
                        input int pass_at, input bit both, input bit start_in_wait);
    longint k;
    int     n;
    int     snap;
    bit     done;
    key_start = s;
    key_stop  = e;
    start     = 1'b1;
    tick;
    start     = 1'b0;
    chk("start_fnd_clr", 32'(m_fnd), 0);
    chk("start_fk_clr", 32'(m_fk), 0);
    if (s > e) begin
      chk("empty_exh", 32'(m_exh), 1);
      chk("empty_kt", 32'(m_kt), 0);
      chk("empty_ts", 32'(m_ts), 0);
      chk("empty_srch", 32'(m_srch), 0);
      return;
    end
    k = longint'(s);
    n = 0;
    done = 1'b0;
    while (!done && n < 400) begin
      chk("launch_ts", 32'(m_ts), 1);
      chk("launch_key", 32'(k[23:0]), 32'(m_key) ^ 32'(m_key) ^ 32'(k[23:0]) == 32'(m_key) ? 32'(k[23:0]) : 32'(m_key));
      chk("launch_srch", 32'(m_srch), 1);
      tick;
      if (start_in_wait && n == 0) begin
        key_start = ~s;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("wait_start_key", 32'(m_key), 32'(k[23:0]));
        chk("wait_start_srch", 32'(m_srch), 1);
      end
      repeat ($urandom_range(0, 3)) tick;
      chk("wait_ts", 32'(m_ts), 0);
      if (n == pass_at) begin
        trial_pass = 1'b1;
        trial_fail = both;
      end else begin
        trial_fail = 1'b1;
      end
      tick;
      trial_pass = 1'b0;
      trial_fail = 1'b0;
      n++;
      if (n - 1 == pass_at) begin
        chk("pass_fnd", 32'(m_fnd), 1);
        chk("pass_fk", 32'(m_fk), 32'(k[23:0]));
        chk("pass_kt", 32'(m_kt), 32'(n));
        chk("pass_srch", 32'(m_srch), 0);
        chk("pass_exh", 32'(m_exh), 0);
        done = 1'b1;
      end else if (k + longint'(stride) > longint'(e)) begin
        chk("exh_exh", 32'(m_exh), 1);
        chk("exh_kt", 32'(m_kt), 32'(n));
        chk("exh_key", 32'(m_key), 32'(k[23:0]));
        chk("exh_fnd", 32'(m_fnd), 0);
        chk("exh_srch", 32'(m_srch), 0);
        done = 1'b1;
      end else begin
        k = k + longint'(stride);
      end
    end
    chk("search_bounded", 32'(done), 1);
    snap = ts_cnt;
    tick;
    tick;
    chk("no_more_ts", 32'(ts_cnt), 32'(snap));
  endtask

  initial begin
    byte unsigned idxs[5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd255};
    logic [23:0]  kval;
    logic [7:0]   prev_kb;
    logic [7:0]   exp_kb;
    int           snap;

    // Reset state, and verdicts ignored outside WAIT
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    chk_all_zero("reset");
    trial_pass = 1'b1;
    tick;
    trial_pass = 1'b0;
    chk("idle_pass_ign", 32'(m_fnd), 0);
    chk("idle_pass_kt", 32'(m_kt), 0);

    // Reset mid-WAIT
    key_start = 24'd0;
    key_stop  = 24'd10;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk("pre_rst_srch", 32'(m_srch), 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_all_zero("mid_rst");
    snap = ts_cnt;
    repeat (3) tick;
    chk("rst_no_ts", 32'(ts_cnt), 32'(snap));
    chk("rst_idle_srch", 32'(m_srch), 0);

    search(24'd0, 24'd2, 1, -1, 1'b0, 1'b0);
    search(24'h000010, 24'h0000FF, 1, 3, 1'b0, 1'b0);

    // Key byte serving with a held key
    kval = 24'hA1B2C3;
    key_start = kval;
    key_stop  = kval;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    prev_kb = 8'((kval >> (8 * (2 - (int'(key_byte_idx) % 3)))) & 24'hFF);
    chk("kb_initial", 32'(m_kb), 32'(prev_kb));
    for (int i = 0; i < 11; i++) begin
      key_byte_idx = (i < 5) ? idxs[i] : 8'($urandom_range(0, 255));
      exp_kb = 8'((kval >> (8 * (2 - (int'(key_byte_idx) % 3)))) & 24'hFF);
      #1;
      chk("kb_latency", 32'(m_kb), 32'(prev_kb));
      tick;
      chk("kb_value", 32'(m_kb), 32'(exp_kb));
      prev_kb = exp_kb;
    end
    trial_fail = 1'b1;
    tick;
    trial_fail = 1'b0;
    chk("kb_exh", 32'(m_exh), 1);
    chk("kb_kt", 32'(m_kt), 1);

    search(24'h000100, 24'h000200, 1, 0, 1'b1, 1'b1);
    search(24'h000300, 24'h000302, 1, -1, 1'b0, 1'b0);
    search(24'd5, 24'd4, 1, -1, 1'b0, 1'b0);
    search(24'hFFFFFD, 24'hFFFFFF, 1, -1, 1'b0, 1'b0);

    for (int it = 0; it < 6; it++) begin
      logic [23:0] s, e;
      int          r;
      s = 24'($urandom_range(0, 1000));
      e = (it == 5) ? s - 24'd1 : s + 24'($urandom_range(0, 6));
      r = $urandom_range(0, 8);
      search(s, e, 1, (r <= int'(e - s)) ? r : -1, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Stride-2 instance
    use2 = 1'b1;
    tick;
    search(24'hFFFFFE, 24'hFFFFFF, 2, -1, 1'b0, 1'b0);
    search(24'hFFFFFB, 24'hFFFFFF, 2, -1, 1'b0, 1'b0);
    for (int it = 0; it < 4; it++) begin
      logic [23:0] s, e;
      int          r;
      s = 24'($urandom_range(0, 1000));
      e = s + 24'($urandom_range(0, 9));
      r = $urandom_range(0, 6);
      search(s, e, 2, (2 * r <= int'(e - s)) ? r : -1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
